// File: rtl/bubble_pkg.sv
// Shared definitions for the bubble memory access sequencer: FSM states,
// default geometry and the wrap-around adder used for loop positions.
package bubble_pkg;

    localparam int LOOP_POSITIONS_DEF = 2053;
    localparam int PAGE_BITS_DEF      = 512;
    localparam int DETECTOR_DELAY_DEF = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPINUP    = 3'd1,
        SEEK      = 3'd2,
        REPLICATE = 3'd3,
        WAIT_DET  = 3'd4,
        TRANSFER  = 3'd5,
        STOP      = 3'd6
    } seq_state_t;

    // (a + b) mod m for a, b < m: one compare-and-subtract, no divider
    function automatic logic [31:0] mod_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] m);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, m}) begin
            mod_add = 32'(sum - {1'b0, m});
        end else begin
            mod_add = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/bubble_position_tracker.sv
// Edge detection of the timing-generator strobes and the absolute minor-loop
// position counter. Edges are held pending until the next tick12 consumes them.
module bubble_position_tracker
    import bubble_pkg::*;
#(
    parameter int LOOP_POSITIONS = LOOP_POSITIONS_DEF,
    parameter int POS_WIDTH      = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 position_change,
    input  logic                 coil_run,
    input  logic                 data_out_strobe,
    output logic                 pos_event,
    output logic                 step,
    output logic                 bit_event,
    output logic [POS_WIDTH-1:0] pos_next,
    output logic [POS_WIDTH-1:0] current_position
);

    logic pc_prev_r;
    logic ds_prev_r;
    logic pc_pend_r;
    logic ds_pend_r;
    logic pc_seen_s;
    logic ds_seen_s;

    // An edge arriving on the tick cycle itself is consumed right away
    assign pc_seen_s = pc_pend_r | (position_change & ~pc_prev_r);
    assign ds_seen_s = ds_pend_r | (~data_out_strobe & ds_prev_r);
    assign pos_event = tick & pc_seen_s;
    assign bit_event = tick & ds_seen_s;
    assign step      = pos_event & coil_run;
    assign pos_next  = POS_WIDTH'(mod_add(32'(current_position), 32'd1, 32'(LOOP_POSITIONS)));

    // Edge history, pending flags and the wrapping position register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_prev_r        <= 1'b0;
            ds_prev_r        <= 1'b0;
            pc_pend_r        <= 1'b0;
            ds_pend_r        <= 1'b0;
            current_position <= {POS_WIDTH{1'b0}};
        end else begin
            pc_prev_r <= position_change;
            ds_prev_r <= data_out_strobe;
            pc_pend_r <= pc_seen_s & ~tick;
            ds_pend_r <= ds_seen_s & ~tick;
            if (step) begin
                current_position <= pos_next;
            end
        end
    end

endmodule

// File: rtl/bubble_access_sequencer.sv
// Host-side bubble memory initiator: spins the field, replicates the requested
// pages at the right loop position and frames the serial bits of each page.
module bubble_access_sequencer
    import bubble_pkg::*;
#(
    parameter int LOOP_POSITIONS = LOOP_POSITIONS_DEF,
    parameter int POS_WIDTH      = 12,
    parameter int REP_OFFSET     = 0,
    parameter int DETECTOR_DELAY = DETECTOR_DELAY_DEF,
    parameter int PAGE_BITS      = PAGE_BITS_DEF,
    parameter int REP_TICKS      = 3,
    parameter int SPINUP_TIMEOUT = 1024
) (
    input  logic                 master_clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_bootloop,
    input  logic [POS_WIDTH-1:0] req_page,
    input  logic [7:0]           req_count,
    input  logic                 position_change,
    input  logic                 coil_run,
    input  logic                 data_out_strobe,
    output logic                 bubble_shift_enable,
    output logic                 replicator_enable,
    output logic                 bootloop_enable,
    output logic [POS_WIDTH-1:0] current_position,
    output logic                 page_start,
    output logic                 bit_strobe,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int TMO_W = $clog2(SPINUP_TIMEOUT + 1);
    localparam int REP_W = $clog2(REP_TICKS + 1);
    localparam int BIT_W = $clog2(PAGE_BITS + 1);
    localparam logic [TMO_W-1:0]     TMO_LOAD = TMO_W'(SPINUP_TIMEOUT - 1);
    localparam logic [REP_W-1:0]     REP_LOAD = REP_W'(REP_TICKS - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(PAGE_BITS - 1);
    localparam logic [POS_WIDTH-1:0] POS_LAST = POS_WIDTH'(LOOP_POSITIONS - 1);

    seq_state_t           state_r, state_nxt;
    logic [1:0]           div_r;
    logic                 tick_s;
    logic [POS_WIDTH-1:0] page_r, page_nxt;
    logic [7:0]           count_r, count_nxt;
    logic [TMO_W-1:0]     tmo_r, tmo_nxt;
    logic [REP_W-1:0]     rep_cnt_r, rep_cnt_nxt;
    logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_nxt;
    logic                 stop_seen_r, stop_seen_nxt;
    logic                 tmo_stop_r, tmo_stop_nxt;
    logic                 bs_nxt, rep_nxt, boot_nxt;
    logic                 page_start_nxt, bit_strobe_nxt, done_nxt, error_nxt;
    logic                 req_ready_nxt, busy_nxt;

    logic                 pos_event_s, step_s, bit_event_s;
    logic [POS_WIDTH-1:0] pos_next_s;
    logic [POS_WIDTH-1:0] rep_target_s, rep_prev_s, first_bit_s;

    bubble_position_tracker #(
        .LOOP_POSITIONS (LOOP_POSITIONS),
        .POS_WIDTH      (POS_WIDTH)
    ) u_tracker (
        .clk              (master_clock),
        .reset            (reset),
        .tick             (tick_s),
        .position_change  (position_change),
        .coil_run         (coil_run),
        .data_out_strobe  (data_out_strobe),
        .pos_event        (pos_event_s),
        .step             (step_s),
        .bit_event        (bit_event_s),
        .pos_next         (pos_next_s),
        .current_position (current_position)
    );

    assign tick_s = (div_r == 2'd3);

    // Replicate one position early so the gate lines up with the target page
    assign rep_target_s = POS_WIDTH'(mod_add(32'(page_r), 32'(REP_OFFSET), 32'(LOOP_POSITIONS)));
    assign first_bit_s  = POS_WIDTH'(mod_add(32'(rep_target_s), 32'(DETECTOR_DELAY), 32'(LOOP_POSITIONS)));
    assign rep_prev_s   = (rep_target_s == {POS_WIDTH{1'b0}}) ? POS_LAST
                                                              : rep_target_s - POS_WIDTH'(1'b1);

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state_r;
        page_nxt       = page_r;
        count_nxt      = count_r;
        tmo_nxt        = tmo_r;
        rep_cnt_nxt    = rep_cnt_r;
        bit_cnt_nxt    = bit_cnt_r;
        stop_seen_nxt  = stop_seen_r;
        tmo_stop_nxt   = tmo_stop_r;
        bs_nxt         = bubble_shift_enable;
        rep_nxt        = replicator_enable;
        boot_nxt       = bootloop_enable;
        page_start_nxt = 1'b0;
        bit_strobe_nxt = 1'b0;
        done_nxt       = 1'b0;
        error_nxt      = 1'b0;

        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    page_nxt     = req_page;
                    count_nxt    = (req_count == 8'd0) ? 8'd1 : req_count;
                    tmo_nxt      = TMO_LOAD;
                    tmo_stop_nxt = 1'b0;
                    bs_nxt       = 1'b0;
                    boot_nxt     = ~req_bootloop;
                    state_nxt    = SPINUP;
                end else begin
                    bs_nxt = 1'b1;
                end
            end
            SPINUP: begin
                if (tick_s && pos_event_s) begin
                    state_nxt = SEEK;
                end else if (tick_s && (tmo_r == {TMO_W{1'b0}})) begin
                    error_nxt     = 1'b1;
                    bs_nxt        = 1'b1;
                    tmo_stop_nxt  = 1'b1;
                    stop_seen_nxt = 1'b0;
                    state_nxt     = STOP;
                end else if (tick_s) begin
                    tmo_nxt = tmo_r - TMO_W'(1'b1);
                end else begin
                    tmo_nxt = tmo_r;
                end
            end
            SEEK: begin
                if (step_s && (pos_next_s == rep_prev_s)) begin
                    rep_nxt     = 1'b0;
                    rep_cnt_nxt = REP_LOAD;
                    state_nxt   = REPLICATE;
                end else begin
                    rep_nxt = 1'b1;
                end
            end
            REPLICATE: begin
                if (tick_s && (rep_cnt_r == {REP_W{1'b0}})) begin
                    rep_nxt   = 1'b1;
                    state_nxt = WAIT_DET;
                end else if (tick_s) begin
                    rep_cnt_nxt = rep_cnt_r - REP_W'(1'b1);
                end else begin
                    rep_cnt_nxt = rep_cnt_r;
                end
            end
            WAIT_DET: begin
                if (step_s && (pos_next_s == first_bit_s)) begin
                    page_start_nxt = 1'b1;
                    bit_cnt_nxt    = {BIT_W{1'b0}};
                    state_nxt      = TRANSFER;
                end else begin
                    page_start_nxt = 1'b0;
                end
            end
            TRANSFER: begin
                if (bit_event_s) begin
                    bit_strobe_nxt = 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
                        count_nxt = count_r - 8'd1;
                        if (count_r == 8'd1) begin
                            bs_nxt        = 1'b1;
                            boot_nxt      = 1'b1;
                            stop_seen_nxt = 1'b0;
                            state_nxt     = STOP;
                        end else begin
                            page_nxt  = POS_WIDTH'(mod_add(32'(page_r), 32'd1, 32'(LOOP_POSITIONS)));
                            state_nxt = SEEK;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt_r + BIT_W'(1'b1);
                    end
                end else begin
                    bit_strobe_nxt = 1'b0;
                end
            end
            STOP: begin
                bs_nxt   = 1'b1;
                boot_nxt = 1'b1;
                // The coils must be seen idle on two consecutive ticks
                if (tick_s && !coil_run && stop_seen_r) begin
                    done_nxt      = ~tmo_stop_r;
                    stop_seen_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else if (tick_s) begin
                    stop_seen_nxt = ~coil_run;
                end else begin
                    stop_seen_nxt = stop_seen_r;
                end
            end
            default: begin
                bs_nxt    = 1'b1;
                rep_nxt   = 1'b1;
                boot_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        endcase

        req_ready_nxt = (state_nxt == IDLE);
        busy_nxt      = (state_nxt != IDLE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_r             <= IDLE;
            div_r               <= 2'd0;
            page_r              <= {POS_WIDTH{1'b0}};
            count_r             <= 8'd0;
            tmo_r               <= {TMO_W{1'b0}};
            rep_cnt_r           <= {REP_W{1'b0}};
            bit_cnt_r           <= {BIT_W{1'b0}};
            stop_seen_r         <= 1'b0;
            tmo_stop_r          <= 1'b0;
            bubble_shift_enable <= 1'b1;
            replicator_enable   <= 1'b1;
            bootloop_enable     <= 1'b1;
            page_start          <= 1'b0;
            bit_strobe          <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            req_ready           <= 1'b1;
            busy                <= 1'b0;
        end else begin
            state_r             <= state_nxt;
            div_r               <= div_r + 2'd1;
            page_r              <= page_nxt;
            count_r             <= count_nxt;
            tmo_r               <= tmo_nxt;
            rep_cnt_r           <= rep_cnt_nxt;
            bit_cnt_r           <= bit_cnt_nxt;
            stop_seen_r         <= stop_seen_nxt;
            tmo_stop_r          <= tmo_stop_nxt;
            bubble_shift_enable <= bs_nxt;
            replicator_enable   <= rep_nxt;
            bootloop_enable     <= boot_nxt;
            page_start          <= page_start_nxt;
            bit_strobe          <= bit_strobe_nxt;
            done                <= done_nxt;
            error               <= error_nxt;
            req_ready           <= req_ready_nxt;
            busy                <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_bubble_access_sequencer.sv
// Directed bench for bubble_access_sequencer with a small behavioural timing
// generator (coil start/stop, position pulses, serial bit strobes).
module tb_bubble_access_sequencer;

    logic        master_clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_bootloop;
    logic [11:0] req_page;
    logic [7:0]  req_count;
    logic        position_change;
    logic        coil_run;
    logic        data_out_strobe;
    logic        bubble_shift_enable;
    logic        replicator_enable;
    logic        bootloop_enable;
    logic [11:0] current_position;
    logic        page_start;
    logic        bit_strobe;
    logic        busy;
    logic        done;
    logic        error;

    int n_chk = 0;
    int n_bad = 0;
    bit pc_enable = 1'b1;

    int n_bits = 0;
    int n_ps = 0;
    int n_done = 0;
    int n_err = 0;
    int n_rep = 0;
    int n_boot_low = 0;
    int n_boot_hi_shift = 0;
    int rep_pos [0:63];
    int rep_len [0:63];
    int ps_pos [0:63];

    bubble_access_sequencer #(
        .LOOP_POSITIONS (16),
        .POS_WIDTH      (12),
        .REP_OFFSET     (0),
        .DETECTOR_DELAY (4),
        .PAGE_BITS      (8),
        .REP_TICKS      (3),
        .SPINUP_TIMEOUT (1024)
    ) dut (
        .master_clock        (master_clock),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_bootloop        (req_bootloop),
        .req_page            (req_page),
        .req_count           (req_count),
        .position_change     (position_change),
        .coil_run            (coil_run),
        .data_out_strobe     (data_out_strobe),
        .bubble_shift_enable (bubble_shift_enable),
        .replicator_enable   (replicator_enable),
        .bootloop_enable     (bootloop_enable),
        .current_position    (current_position),
        .page_start          (page_start),
        .bit_strobe          (bit_strobe),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 master_clock = ~master_clock;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Timing generator: coil follows /BS, a position pulse every 32 cycles,
    // eight serial bits (one fall every 8 cycles) after each page_start.
    initial begin
        int coil_cnt;
        int pc_phase;
        int ds_phase;
        int bits_left;
        position_change = 1'b0;
        coil_run        = 1'b0;
        data_out_strobe = 1'b0;
        coil_cnt = 0; pc_phase = 0; ds_phase = 0; bits_left = 0;
        forever begin
            @(negedge master_clock);
            if (!bubble_shift_enable && !coil_run) begin
                coil_cnt++;
                if (coil_cnt >= 8) begin coil_run = 1'b1; coil_cnt = 0; end
            end else if (bubble_shift_enable && coil_run) begin
                coil_cnt++;
                if (coil_cnt >= 12) begin coil_run = 1'b0; coil_cnt = 0; end
            end else begin
                coil_cnt = 0;
            end
            if (coil_run && pc_enable) begin
                pc_phase = (pc_phase + 1) % 32;
                position_change = (pc_phase < 4);
            end else begin
                pc_phase = 0;
                position_change = 1'b0;
            end
            if (reset || bubble_shift_enable) begin
                bits_left = 0;
            end else if (page_start) begin
                bits_left = 8; ds_phase = 0;
            end else if (bits_left > 0) begin
                ds_phase++;
                if (ds_phase == 8) begin ds_phase = 0; bits_left--; end
            end
            data_out_strobe = (bits_left > 0) && (ds_phase >= 1) && (ds_phase <= 4);
        end
    end

    // Output monitor
    initial begin
        logic rep_q;
        int   rep_run;
        rep_q = 1'b1;
        rep_run = 0;
        forever begin
            @(negedge master_clock);
            if (bit_strobe) n_bits++;
            if (page_start) begin
                if (n_ps < 64) ps_pos[n_ps] = int'(current_position);
                n_ps++;
            end
            if (done) n_done++;
            if (error) n_err++;
            if (rep_q && !replicator_enable && n_rep < 64) rep_pos[n_rep] = int'(current_position);
            if (!replicator_enable) begin
                rep_run++;
            end else if (rep_run > 0) begin
                if (n_rep < 64) rep_len[n_rep] = rep_run;
                n_rep++;
                rep_run = 0;
            end
            if (!bootloop_enable) n_boot_low++;
            if (!bubble_shift_enable && bootloop_enable) n_boot_hi_shift++;
            rep_q = replicator_enable;
        end
    end

    task automatic send_req(input int page, input int count, input bit boot);
        @(negedge master_clock);
        req_valid    = 1'b1;
        req_page     = 12'(page);
        req_count    = 8'(count);
        req_bootloop = boot;
        @(negedge master_clock);
        req_valid = 1'b0;
        check_val("accept_bs_low", int'(bubble_shift_enable), 0);
        check_val("accept_busy", int'(busy), 1);
        check_val("accept_not_ready", int'(req_ready), 0);
    endtask

    task automatic wait_end(input string tag, input int d0, input int e0, input int budget);
        int cnt;
        cnt = 0;
        while (cnt < budget && n_done == d0 && n_err == e0) begin
            @(negedge master_clock);
            cnt++;
        end
        check_val(tag, int'(cnt < budget), 1);
        repeat (2) @(negedge master_clock);
    endtask

    initial begin
        int sb, sp, sd, se, sr, sbl, sbh, cnt;
        reset = 1'b1; req_valid = 1'b0; req_bootloop = 1'b0;
        req_page = 12'd0; req_count = 8'd0;
        repeat (3) @(negedge master_clock);
        reset = 1'b0;
        @(negedge master_clock);
        check_val("rst_bs", int'(bubble_shift_enable), 1);
        check_val("rst_rep", int'(replicator_enable), 1);
        check_val("rst_boot", int'(bootloop_enable), 1);
        check_val("rst_ready", int'(req_ready), 1);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_pos", int'(current_position), 0);

        // 1: page 5, one page
        sb = n_bits; sp = n_ps; sd = n_done; se = n_err; sr = n_rep; sbl = n_boot_low;
        send_req(5, 1, 1'b0);
        wait_end("t1_bound", sd, se, 6000);
        check_val("t1_rep_pos", rep_pos[sr], 4);
        check_val("t1_rep_len", rep_len[sr], 12);
        check_val("t1_ps_pos", ps_pos[sp], 9);
        check_val("t1_bits", n_bits - sb, 8);
        check_val("t1_done", n_done - sd, 1);
        check_val("t1_err", n_err - se, 0);
        check_val("t1_bs_high", int'(bubble_shift_enable), 1);
        check_val("t1_ready", int'(req_ready), 1);
        check_val("t1_boot_untouched", n_boot_low - sbl, 0);

        // 2: three pages across the loop wrap
        sb = n_bits; sp = n_ps; sd = n_done; se = n_err; sr = n_rep;
        send_req(14, 3, 1'b0);
        wait_end("t2_bound", sd, se, 8000);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("t2_rep_pos%0d", i), rep_pos[sr + i], (13 + i) % 16);
            check_val($sformatf("t2_ps_pos%0d", i), ps_pos[sp + i], 2 + i);
        end
        check_val("t2_bits", n_bits - sb, 24);
        check_val("t2_pages", n_ps - sp, 3);
        check_val("t2_done", n_done - sd, 1);

        // 3: spin-up timeout
        sd = n_done; se = n_err;
        pc_enable = 1'b0;
        send_req(3, 1, 1'b0);
        wait_end("t3_bound", sd, se, 6000);
        check_val("t3_err", n_err - se, 1);
        check_val("t3_bs_high", int'(bubble_shift_enable), 1);
        cnt = 0;
        while (cnt < 300 && !req_ready) begin
            @(negedge master_clock);
            cnt++;
        end
        check_val("t3_ready", int'(req_ready), 1);
        check_val("t3_no_done", n_done - sd, 0);
        pc_enable = 1'b1;

        // 4: bootloop request, count 0 treated as 1
        sb = n_bits; sd = n_done; se = n_err; sbh = n_boot_hi_shift;
        send_req(7, 0, 1'b1);
        check_val("t4_boot_low", int'(bootloop_enable), 0);
        wait_end("t4_bound", sd, se, 6000);
        check_val("t4_bits", n_bits - sb, 8);
        check_val("t4_done", n_done - sd, 1);
        check_val("t4_boot_held", n_boot_hi_shift - sbh, 0);
        check_val("t4_boot_release", int'(bootloop_enable), 1);

        // 5: reset in the middle of a transfer
        sb = n_bits;
        send_req(2, 1, 1'b0);
        cnt = 0;
        while (cnt < 6000 && (n_bits - sb) < 3) begin
            @(negedge master_clock);
            cnt++;
        end
        check_val("t5_reach_bit3", int'(cnt < 6000), 1);
        reset = 1'b1;
        @(negedge master_clock);
        check_val("t5_bs", int'(bubble_shift_enable), 1);
        check_val("t5_rep", int'(replicator_enable), 1);
        check_val("t5_boot", int'(bootloop_enable), 1);
        check_val("t5_ready", int'(req_ready), 1);
        check_val("t5_busy", int'(busy), 0);
        check_val("t5_strobes", int'({done, error, bit_strobe, page_start}), 0);
        check_val("t5_pos", int'(current_position), 0);
        reset = 1'b0;
        sb = n_bits; sp = n_ps; sd = n_done; se = n_err;
        send_req(6, 1, 1'b0);
        wait_end("t5_bound", sd, se, 6000);
        check_val("t5_bits", n_bits - sb, 8);
        check_val("t5_ps_pos", ps_pos[sp], 10);
        check_val("t5_done", n_done - sd, 1);

        // 6: requests while busy are ignored
        sb = n_bits; sp = n_ps; sd = n_done; se = n_err;
        send_req(10, 2, 1'b0);
        req_valid = 1'b1; req_page = 12'd1; req_count = 8'd5;
        repeat (50) @(negedge master_clock);
        check_val("t6_ready_low", int'(req_ready), 0);
        req_valid = 1'b0;
        wait_end("t6_bound", sd, se, 8000);
        repeat (600) @(negedge master_clock);
        check_val("t6_done", n_done - sd, 1);
        check_val("t6_bits", n_bits - sb, 16);
        check_val("t6_pages", n_ps - sp, 2);
        check_val("t6_ps_pos0", ps_pos[sp], 14);
        check_val("t6_ps_pos1", ps_pos[sp + 1], 15);
        check_val("t6_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
